// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bnn_pkg
// Description : Shared definitions for the BNN accelerator datapath: state
//               encodings of the partial-sum binarizer and MAC output sizing.
// Revision    : 1.0 - initial release
// ============================================================================
package bnn_pkg;

  // Binarizer state encodings
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  // One MAC beat is a 5x5 XNOR popcount: 0..25 fits in 5 bits
  localparam int MAC_OUT_WIDTH  = 5;
  localparam int MAX_KERNEL_POP = 25;

  typedef enum logic [1:0] {
    ST_IDLE  = IDLE,
    ST_ACCUM = ACCUM,
    ST_HOLD  = HOLD
  } state_t;

endpackage
`default_nettype wire

// File: rtl/psum_binarizer_if.sv
`default_nettype none
// ============================================================================
// Module      : psum_binarizer_if
// Description : Result handshake between the binarizer and the ofmap writer.
//               master = binarizer (drives result + valid),
//               slave  = consumer  (drives ready).
//   out_bit   : binary activation
//   psum_out  : final accumulated sum, valid with out_valid
//   out_valid : result available
//   out_ready : consumer accepts the result
// Revision    : 1.0 - initial release
// ============================================================================
interface psum_binarizer_if #(
  parameter int ACC_WIDTH = 16
);
  logic                 out_bit;
  logic [ACC_WIDTH-1:0] psum_out;
  logic                 out_valid;
  logic                 out_ready;

  modport master (output out_bit, output psum_out, output out_valid, input out_ready);
  modport slave  (input out_bit, input psum_out, input out_valid, output out_ready);
endinterface
`default_nettype wire

// File: rtl/psum_sat_add.sv
`default_nettype none
// ============================================================================
// Module      : psum_sat_add
// Description : Combinational unsigned saturating adder. The sum is formed one
//               bit wider; a carry out clamps the result to all-ones.
//   a, b : addends (ACC_WIDTH)
//   sum  : saturated sum (ACC_WIDTH)
//   sat  : high when the result was clamped
// Revision    : 1.0 - initial release
// ============================================================================
module psum_sat_add #(
  parameter int ACC_WIDTH = 16
) (
  input  logic [ACC_WIDTH-1:0] a,
  input  logic [ACC_WIDTH-1:0] b,
  output logic [ACC_WIDTH-1:0] sum,
  output logic                 sat
);
  logic [ACC_WIDTH:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b};
  assign sat      = full_sum[ACC_WIDTH];
  assign sum      = sat ? {ACC_WIDTH{1'b1}} : full_sum[ACC_WIDTH-1:0];
endmodule
`default_nettype wire

// File: rtl/psum_binarizer.sv
`default_nettype none
// ============================================================================
// Module      : psum_binarizer
// Description : Accumulates num_channels MAC popcount beats into a saturating
//               partial sum, applies the folded batch-norm threshold and
//               presents one activation bit per pixel on a valid/ready port.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : begin a pixel; samples num_channels/threshold/invert
//   num_channels  : number of mac_in beats to accumulate
//   threshold     : unsigned compare value (popcount domain)
//   invert        : 1 = negative BN gamma, compare direction flipped
//   mac_in/valid  : MAC popcount beat
//   res           : result handshake (out_bit, psum_out, out_valid, out_ready)
//   busy          : high in ACCUM or HOLD
//   overflow      : sticky, accumulator saturated
//   mac_drop      : sticky, mac_valid seen outside ACCUM
// Revision    : 1.0 - initial release
// ============================================================================
module psum_binarizer
  import bnn_pkg::*;
#(
  parameter int ACC_WIDTH = 16,
  parameter int CH_WIDTH  = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [CH_WIDTH-1:0]      num_channels,
  input  logic [ACC_WIDTH-1:0]     threshold,
  input  logic                     invert,
  input  logic [MAC_OUT_WIDTH-1:0] mac_in,
  input  logic                     mac_valid,
  psum_binarizer_if.master         res,
  output logic                     busy,
  output logic                     overflow,
  output logic                     mac_drop
);

  state_t               state, state_nxt;
  logic [ACC_WIDTH-1:0] acc;
  logic [CH_WIDTH-1:0]  cnt;
  logic [CH_WIDTH-1:0]  cfg_n;
  logic [ACC_WIDTH-1:0] cfg_thr;
  logic                 cfg_inv;
  logic                 bit_r;
  logic [ACC_WIDTH-1:0] psum_r;
  logic                 ovf_r;
  logic                 drop_r;

  logic [ACC_WIDTH-1:0] add_b;
  logic [ACC_WIDTH-1:0] sum;
  logic                 sat;
  logic                 take_start;
  logic                 beat;
  logic                 last_beat;

  function automatic logic binarize(input logic [ACC_WIDTH-1:0] p,
                                    input logic [ACC_WIDTH-1:0] thr,
                                    input logic                 inv);
    return inv ? (p < thr) : (p >= thr);
  endfunction

  assign add_b = {{(ACC_WIDTH-MAC_OUT_WIDTH){1'b0}}, mac_in};

  psum_sat_add #(.ACC_WIDTH(ACC_WIDTH)) u_sat_add (
    .a   (acc),
    .b   (add_b),
    .sum (sum),
    .sat (sat)
  );

  // A new pixel is accepted from IDLE, or from HOLD only together with the
  // handshake so back-to-back pixels need no idle cycle.
  assign take_start = start && ((state == ST_IDLE) || ((state == ST_HOLD) && res.out_ready));
  assign beat       = (state == ST_ACCUM) && mac_valid;
  // cfg_n is never zero in ACCUM, so cfg_n-1 cannot wrap here.
  assign last_beat  = beat && (cnt == cfg_n - 1'b1);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (take_start) state_nxt = (num_channels == '0) ? ST_HOLD : ST_ACCUM;
      end
      ST_ACCUM: begin
        if (last_beat) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (take_start)        state_nxt = (num_channels == '0) ? ST_HOLD : ST_ACCUM;
        else if (res.out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      acc     <= '0;
      cnt     <= '0;
      cfg_n   <= '0;
      cfg_thr <= '0;
      cfg_inv <= 1'b0;
      bit_r   <= 1'b0;
      psum_r  <= '0;
      ovf_r   <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      state <= state_nxt;

      if (take_start) begin
        cfg_n   <= num_channels;
        cfg_thr <= threshold;
        cfg_inv <= invert;
        acc     <= '0;
        cnt     <= '0;
        // Zero-channel pixel: result is the threshold test of an empty sum.
        if (num_channels == '0) begin
          psum_r <= '0;
          bit_r  <= binarize('0, threshold, invert);
        end
      end

      if (beat) begin
        acc   <= sum;
        cnt   <= cnt + 1'b1;
        ovf_r <= ovf_r | sat;
        if (last_beat) begin
          psum_r <= sum;
          bit_r  <= binarize(sum, cfg_thr, cfg_inv);
        end
      end

      if (mac_valid && (state != ST_ACCUM)) drop_r <= 1'b1;
    end
  end

  assign res.out_valid = (state == ST_HOLD);
  assign res.out_bit   = bit_r;
  assign res.psum_out  = psum_r;
  assign busy          = (state != ST_IDLE);
  assign overflow      = ovf_r;
  assign mac_drop      = drop_r;

endmodule
`default_nettype wire

// File: tb/tb_psum_binarizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_psum_binarizer
// Description : Directed self-checking bench for psum_binarizer. A 16-bit and
//               an 8-bit instance share stimulus; the 8-bit one is held in
//               reset until the saturation scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_binarizer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rst8_n;
  logic        start;
  logic [9:0]  num_channels;
  logic [15:0] threshold;
  logic        invert;
  logic [4:0]  mac_in;
  logic        mac_valid;
  logic        out_ready;

  logic busy16, ovf16, drop16;
  logic busy8, ovf8, drop8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  psum_binarizer_if #(.ACC_WIDTH(16)) res16 ();
  psum_binarizer_if #(.ACC_WIDTH(8))  res8 ();

  assign res16.out_ready = out_ready;
  assign res8.out_ready  = out_ready;

  psum_binarizer #(.ACC_WIDTH(16), .CH_WIDTH(10)) dut16 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_channels (num_channels),
    .threshold    (threshold),
    .invert       (invert),
    .mac_in       (mac_in),
    .mac_valid    (mac_valid),
    .res          (res16),
    .busy         (busy16),
    .overflow     (ovf16),
    .mac_drop     (drop16)
  );

  psum_binarizer #(.ACC_WIDTH(8), .CH_WIDTH(10)) dut8 (
    .clk          (clk),
    .rst_n        (rst8_n),
    .start        (start),
    .num_channels (num_channels),
    .threshold    (threshold[7:0]),
    .invert       (invert),
    .mac_in       (mac_in),
    .mac_valid    (mac_valid),
    .res          (res8),
    .busy         (busy8),
    .overflow     (ovf8),
    .mac_drop     (drop8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_px(input int n, input int thr, input logic inv);
    num_channels = 10'(n);
    threshold    = 16'(thr);
    invert       = inv;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic beat(input int v);
    mac_in    = 5'(v);
    mac_valid = 1'b1;
    tick();
    mac_valid = 1'b0;
  endtask

  task automatic idle_cycle();
    tick();
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rst8_n = 1'b0;
    start = 1'b0; num_channels = '0; threshold = '0; invert = 1'b0;
    mac_in = '0; mac_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();

    check("rst_out_bit",   32'(res16.out_bit),   0);
    check("rst_psum",      32'(res16.psum_out),  0);
    check("rst_out_valid", 32'(res16.out_valid), 0);
    check("rst_busy",      32'(busy16),          0);
    check("rst_overflow",  32'(ovf16),           0);
    check("rst_mac_drop",  32'(drop16),          0);
    rst_n = 1'b1;
    tick();

    // N=4, thr=40: 9+10+11+12 = 42 >= 40
    start_px(4, 40, 1'b0);
    check("p1_busy", 32'(busy16), 1);
    beat(9); beat(10); beat(11);
    check("p1_valid_early", 32'(res16.out_valid), 0);
    beat(12);
    check("p1_valid", 32'(res16.out_valid), 1);
    check("p1_psum",  32'(res16.psum_out),  42);
    check("p1_bit",   32'(res16.out_bit),   1);
    handshake();
    check("p1_valid_after", 32'(res16.out_valid), 0);
    check("p1_busy_after",  32'(busy16),          0);

    // invert=1: 42 < 40 is false
    start_px(4, 40, 1'b1);
    beat(9); beat(10); beat(11); beat(12);
    check("p2_psum", 32'(res16.psum_out), 42);
    check("p2_bit",  32'(res16.out_bit),  0);
    handshake();

    // thr=43: 42 >= 43 is false
    start_px(4, 43, 1'b0);
    beat(9); beat(10); beat(11); beat(12);
    check("p3_bit", 32'(res16.out_bit), 0);
    handshake();

    // gapped beats 1,0,0,1,1,0,1, then stall the consumer for 5 cycles
    start_px(4, 40, 1'b0);
    beat(9); idle_cycle(); idle_cycle(); beat(10); beat(11); idle_cycle();
    check("p4_valid_early", 32'(res16.out_valid), 0);
    check("p4_busy_gap",    32'(busy16),          1);
    beat(12);
    check("p4_valid", 32'(res16.out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      idle_cycle();
      check("p4_hold_valid", 32'(res16.out_valid), 1);
      check("p4_hold_psum",  32'(res16.psum_out),  42);
      check("p4_hold_bit",   32'(res16.out_bit),   1);
    end
    handshake();
    check("p4_single_hs", 32'(res16.out_valid), 0);
    check("p4_no_drop",   32'(drop16),          0);

    // N=0, thr=0: result the cycle after start, 0 >= 0
    start_px(0, 0, 1'b0);
    check("p5_valid", 32'(res16.out_valid), 1);
    check("p5_psum",  32'(res16.psum_out),  0);
    check("p5_bit",   32'(res16.out_bit),   1);

    // handshake and start together: straight into ACCUM, 3+4 = 7 >= 5
    out_ready = 1'b1;
    start_px(2, 5, 1'b0);
    out_ready = 1'b0;
    check("p6_valid_accum", 32'(res16.out_valid), 0);
    check("p6_busy",        32'(busy16),          1);
    beat(3); beat(4);
    check("p6_valid", 32'(res16.out_valid), 1);
    check("p6_psum",  32'(res16.psum_out),  7);
    check("p6_bit",   32'(res16.out_bit),   1);
    handshake();

    // mac_valid while IDLE sets the sticky drop flag
    check("drop_before", 32'(drop16), 0);
    beat(5);
    check("drop_after", 32'(drop16), 1);
    idle_cycle();
    check("drop_sticky", 32'(drop16), 1);

    // asynchronous reset mid-ACCUM
    start_px(4, 10, 1'b0);
    beat(25); beat(25);
    rst_n = 1'b0;
    #2;
    check("ar_busy",  32'(busy16),          0);
    check("ar_valid", 32'(res16.out_valid), 0);
    check("ar_drop",  32'(drop16),          0);
    check("ar_psum",  32'(res16.psum_out),  0);
    tick();
    rst_n = 1'b1;
    tick();
    // partial sum lost: 7 alone, 7 < 0 false
    start_px(1, 0, 1'b1);
    beat(7);
    check("ar_psum_new", 32'(res16.psum_out), 7);
    check("ar_bit_new",  32'(res16.out_bit),  0);
    handshake();

    // 8-bit saturation: 12 x 25 = 300 -> 255 on both overflow and psum
    rst8_n = 1'b1;
    tick();
    start_px(12, 100, 1'b0);
    for (int i = 0; i < 10; i++) beat(25);
    check("s8_no_ovf_250", 32'(ovf8), 0);
    beat(25);
    check("s8_ovf_275", 32'(ovf8), 1);
    beat(25);
    check("s8_psum",  32'(res8.psum_out), 255);
    check("s8_bit",   32'(res8.out_bit),  1);
    check("s16_psum", 32'(res16.psum_out), 300);
    check("s16_ovf",  32'(ovf16), 0);
    handshake();
    start_px(1, 200, 1'b0);
    beat(3);
    check("s8_next_psum", 32'(res8.psum_out), 3);
    check("s8_next_bit",  32'(res8.out_bit),  0);
    check("s8_ovf_stick", 32'(ovf8), 1);
    handshake();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/psum_binarizer.md
# psum_binarizer

Downstream stage of the MAC unit in the BNN accelerator. Consumes the per-cycle 5-bit XNOR-popcount result (`mac_in`, 0..25) over a programmed number of input channels. Accumulates the values into a partial sum, then applies the folded batch-norm threshold. Produces one binary activation bit per output pixel through a valid/ready handshake toward the ofmap writer.

## Interface
Parameters:
- ACC_WIDTH, 16: accumulator and threshold width.
- CH_WIDTH, 10: width of channel count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  begin one pixel; samples num_channels, threshold, invert.
- num_channels  in  CH_WIDTH  number of mac_in beats to accumulate.
- threshold  in  ACC_WIDTH  unsigned compare value, in the popcount domain.
- invert  in  1  1 = negative BN gamma; compare direction is flipped.
- mac_in  in  5  MAC popcount result.
- mac_valid  in  1  mac_in is valid this cycle.
- out_bit  out  1  binary activation.
- psum_out  out  ACC_WIDTH  final accumulated sum; valid with out_valid.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  high in ACCUM or HOLD.
- overflow  out  1  sticky: the accumulator saturated.
- mac_drop  out  1  sticky: mac_valid arrived outside ACCUM.

## Operation
- States: IDLE, ACCUM, HOLD.
- **IDLE**
  - On start: latch the config, clear acc and cnt.
  - If num_channels==0: go to HOLD with acc=0.
  - Otherwise: go to ACCUM.
- **ACCUM**
  - On each mac_valid: acc <= sat(acc + mac_in) and cnt++.
  - On the beat where cnt == num_channels-1: register out_bit and psum_out from the post-add sum, then go to HOLD.
  - mac_valid low: hold the state.
- **HOLD**
  - out_valid=1; out_bit and psum_out are stable until the handshake.
  - On out_ready: go to IDLE.
  - If out_ready and start in the same cycle: load the new config and go directly to ACCUM, or to HOLD if num_channels==0.
- Threshold rule:
  - invert=0: out_bit = (psum >= threshold).
  - invert=1: out_bit = (psum < threshold).
- Saturation:
  - The sum is computed at ACC_WIDTH+1 bits.
  - If the MSB is set: clamp acc to 2^ACC_WIDTH-1 and set overflow.
- Ignored or flagged inputs:
  - start is ignored in ACCUM, and in HOLD without out_ready.
  - mac_valid in IDLE or HOLD: data discarded, mac_drop set.
- The sticky flags clear only on reset.

## Timing
- Reset values: out_bit=0, psum_out=0, out_valid=0, busy=0, overflow=0, mac_drop=0; state=IDLE; acc=0, cnt=0.
- Latency: out_valid rises the cycle after the final mac_valid beat.
- Pixel cost:
  - N-channel pixel with continuous mac_valid: start + N beats, out_valid on cycle N+1 after start.
  - Back-to-back pixels cost no idle cycles between them when start coincides with the handshake.
- out_valid holds while out_ready=0, with no change to outputs.
- busy is registered and rises the cycle after start.
- rst_n asserted mid-ACCUM or mid-HOLD: immediate return to reset values; the partial sum is lost.

## Structure
- Shared package bnn_pkg:
  - state encoding localparams (IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2);
  - MAC_OUT_WIDTH=5;
  - MAX_KERNEL_POP=25.
- Sub-module psum_sat_add: combinational ACC_WIDTH saturating adder, outputs sum and sat flag; reused by later multi-kernel accumulation.
- Remainder is one always_ff FSM/datapath plus combinational compare.

## Test plan
- start with N=4, threshold=40, invert=0, mac_in 9,10,11,12 continuous → out_valid one cycle after the last beat; psum_out=42, out_bit=1.
- Same stimulus with invert=1 → out_bit=0. With threshold=43, invert=0 → out_bit=0.
- mac_valid gaps (pattern 1,0,0,1,1,0,1) with N=4 → same psum as contiguous; completion on the 4th valid beat; out_ready held low 5 cycles → outputs stable, single handshake.
- ACC_WIDTH=8, N=12, mac_in=25 each → psum_out=255, overflow=1 and stays set after the next pixel.
- N=0 → out_valid the cycle after start; psum_out=0; out_bit=1 if threshold=0.
- out_ready and start in the same cycle:
  - next pixel accumulates immediately with no IDLE cycle.
  - mac_valid in IDLE → mac_drop=1.
  - rst_n pulsed mid-ACCUM → all outputs 0 and state IDLE.
